// File: rtl/t1_idle_monitor.sv
// Quiescence and hang detector: tracks per-source busy and outstanding requests,
// raises idle after a programmable quiet run, and flags commit stalls and accounting errors.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_BUSY  | design active (or held by initFlag); no quiet run in progress
// ST_DRAIN | quiet run in progress, quiet_cnt cycles seen so far
// ST_IDLE  | quiet for at least QUIET_CYCLES consecutive cycles
module t1_idle_monitor #(
    parameter int NUM_SRC      = 4,
    parameter int CNT_W        = 8,
    parameter int QUIET_CYCLES = 16,
    parameter int STALL_W      = 32,
    localparam int ERR_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               initFlag,
    input  logic [NUM_SRC-1:0] busy,
    input  logic [NUM_SRC-1:0] reqFire,
    input  logic [NUM_SRC-1:0] respFire,
    input  logic               commitValid,
    input  logic [STALL_W-1:0] stallLimit,
    output logic               idle,
    output logic               stallTimeout,
    output logic               underflowErr,
    output logic               overflowErr,
    output logic [ERR_W-1:0]   errSrc
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_BUSY  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [QW-1:0]      quiet_cnt;
    logic [QW-1:0]      quiet_cnt_nxt;
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_inc;
    logic               stall_clr;
    logic               stall_hit;

    logic [CNT_W-1:0]   out_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] cnt_nz;
    logic [NUM_SRC-1:0] uf_vec;
    logic [NUM_SRC-1:0] of_vec;
    logic [NUM_SRC-1:0] err_vec;
    logic [ERR_W-1:0]   first_err;
    logic               quiet;

    always_comb begin
        cnt_nz = '0;
        uf_vec = '0;
        of_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_nz[i] = |out_cnt[i];
            uf_vec[i] = respFire[i] & ~reqFire[i] & ~(|out_cnt[i]);
            of_vec[i] = reqFire[i] & ~respFire[i] & (&out_cnt[i]);
        end
    end

    assign err_vec = uf_vec | of_vec;

    // Descending scan so the lowest erroring index wins.
    always_comb begin
        first_err = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (err_vec[i]) first_err = ERR_W'(i);
        end
    end

    assign quiet = ~(|busy) & ~(|reqFire) & ~(|respFire) & ~(|cnt_nz);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) out_cnt[i] <= '0;
            underflowErr <= 1'b0;
            overflowErr  <= 1'b0;
            errSrc       <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (reqFire[i] && !respFire[i] && !(&out_cnt[i]))
                    out_cnt[i] <= out_cnt[i] + CNT_W'(1);
                else if (respFire[i] && !reqFire[i] && cnt_nz[i])
                    out_cnt[i] <= out_cnt[i] - CNT_W'(1);
            end
            if (|uf_vec) underflowErr <= 1'b1;
            if (|of_vec) overflowErr  <= 1'b1;
            if (!underflowErr && !overflowErr && (|err_vec)) errSrc <= first_err;
        end
    end

    always_comb begin
        state_nxt     = state;
        quiet_cnt_nxt = quiet_cnt;
        if (initFlag) begin
            state_nxt     = ST_BUSY;
            quiet_cnt_nxt = '0;
        end else begin
            case (state)
                ST_BUSY: begin
                    if (quiet) begin
                        if (QUIET_CYCLES == 1) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt     = ST_DRAIN;
                            quiet_cnt_nxt = QW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!quiet) begin
                        state_nxt     = ST_BUSY;
                        quiet_cnt_nxt = '0;
                    end else if (quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
                        state_nxt     = ST_IDLE;
                        quiet_cnt_nxt = '0;
                    end else begin
                        quiet_cnt_nxt = quiet_cnt + QW'(1);
                    end
                end
                ST_IDLE: begin
                    if (!quiet) begin
                        state_nxt     = ST_BUSY;
                        quiet_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt     = ST_BUSY;
                    quiet_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign stall_inc = (&stall_cnt) ? stall_cnt : stall_cnt + STALL_W'(1);
    assign stall_clr = initFlag | commitValid | (state_nxt == ST_IDLE);
    assign stall_hit = !stall_clr && (stallLimit != '0) && (stall_inc == stallLimit);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_BUSY;
            quiet_cnt    <= '0;
            idle         <= 1'b0;
            stall_cnt    <= '0;
            stallTimeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            quiet_cnt <= quiet_cnt_nxt;
            idle      <= (state_nxt == ST_IDLE);
            stall_cnt <= stall_clr ? '0 : stall_inc;
            if (stall_hit) stallTimeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_t1_idle_monitor.sv
// Scoreboard bench for t1_idle_monitor: a run-length reference model pushes expected
// outputs before each edge; they are popped and compared just after the edge.
module tb_t1_idle_monitor;

    localparam int Q    = 16;
    localparam int CMAX = 255;

    logic        clock = 1'b0;
    logic        reset;
    logic        initFlag;
    logic [3:0]  busy;
    logic [3:0]  reqFire;
    logic [3:0]  respFire;
    logic        commitValid;
    logic [31:0] stallLimit;
    logic        idle;
    logic        stallTimeout;
    logic        underflowErr;
    logic        overflowErr;
    logic [1:0]  errSrc;

    // Narrow-counter, single-cycle-quiet instance for the saturation boundary.
    logic        zero1;
    logic [0:0]  busy2;
    logic [0:0]  req2;
    logic [0:0]  resp2;
    logic [31:0] limit2;
    logic        idle2;
    logic        to2;
    logic        uf2;
    logic        of2;
    logic [0:0]  src2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       idle;
        logic       to;
        logic       uf;
        logic       of;
        logic [1:0] src;
    } exp_t;

    exp_t sb[$];

    int          m_out [4];
    int          m_run;
    logic        m_idle;
    logic [31:0] m_stall;
    logic        m_to;
    logic        m_uf;
    logic        m_of;
    logic [1:0]  m_src;

    always #5 clock = ~clock;

    t1_idle_monitor dut (
        .clock       (clock),
        .reset       (reset),
        .initFlag    (initFlag),
        .busy        (busy),
        .reqFire     (reqFire),
        .respFire    (respFire),
        .commitValid (commitValid),
        .stallLimit  (stallLimit),
        .idle        (idle),
        .stallTimeout(stallTimeout),
        .underflowErr(underflowErr),
        .overflowErr (overflowErr),
        .errSrc      (errSrc)
    );

    t1_idle_monitor #(.NUM_SRC(1), .CNT_W(2), .QUIET_CYCLES(1), .STALL_W(32)) dut2 (
        .clock       (clock),
        .reset       (reset),
        .initFlag    (zero1),
        .busy        (busy2),
        .reqFire     (req2),
        .respFire    (resp2),
        .commitValid (zero1),
        .stallLimit  (limit2),
        .idle        (idle2),
        .stallTimeout(to2),
        .underflowErr(uf2),
        .overflowErr (of2),
        .errSrc      (src2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        logic        q;
        logic        any_err;
        logic        nu;
        logic        no;
        logic        u;
        logic        o;
        int          first;
        logic [31:0] inc;
        exp_t        e;
        exp_t        got;

        q = (busy == 4'd0) && (reqFire == 4'd0) && (respFire == 4'd0);
        for (int i = 0; i < 4; i++) if (m_out[i] != 0) q = 1'b0;

        if (reset) begin
            for (int i = 0; i < 4; i++) m_out[i] = 0;
            m_run = 0; m_idle = 0; m_stall = '0;
            m_to = 0; m_uf = 0; m_of = 0; m_src = '0;
        end else begin
            any_err = 0; nu = 0; no = 0; first = 0;
            for (int i = 0; i < 4; i++) begin
                u = respFire[i] && !reqFire[i] && (m_out[i] == 0);
                o = reqFire[i] && !respFire[i] && (m_out[i] == CMAX);
                if ((u || o) && !any_err) begin
                    first   = i;
                    any_err = 1;
                end
                if (u) nu = 1;
                if (o) no = 1;
                if (reqFire[i] && !respFire[i] && m_out[i] != CMAX) m_out[i]++;
                else if (respFire[i] && !reqFire[i] && m_out[i] != 0) m_out[i]--;
            end
            if (any_err && !m_uf && !m_of) m_src = 2'(first);
            m_uf = m_uf | nu;
            m_of = m_of | no;

            if (initFlag || !q) m_run = 0;
            else if (m_run < Q) m_run++;
            m_idle = (m_run >= Q);

            if (initFlag || commitValid || m_idle) begin
                m_stall = '0;
            end else begin
                inc = (m_stall == 32'hFFFF_FFFF) ? m_stall : m_stall + 32'd1;
                if (stallLimit != 0 && inc == stallLimit) m_to = 1;
                m_stall = inc;
            end
        end

        e.idle = m_idle; e.to = m_to; e.uf = m_uf; e.of = m_of; e.src = m_src;
        sb.push_back(e);

        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk("idle",     {31'd0, idle},         {31'd0, got.idle});
        chk("stallTo",  {31'd0, stallTimeout}, {31'd0, got.to});
        chk("underflow",{31'd0, underflowErr}, {31'd0, got.uf});
        chk("overflow", {31'd0, overflowErr},  {31'd0, got.of});
        chk("errSrc",   {30'd0, errSrc},       {30'd0, got.src});
    endtask

    task automatic zero_inputs();
        initFlag = 0; busy = '0; reqFire = '0; respFire = '0;
        commitValid = 0; stallLimit = '0;
        busy2 = '0; req2 = '0; resp2 = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    initial begin
        zero1  = 1'b0;
        limit2 = '0;
        zero_inputs();

        // Reset with noisy inputs must still land on reset values.
        reset = 1;
        busy = 4'hF; reqFire = 4'hF; respFire = 4'h5; commitValid = 1; stallLimit = 32'd3;
        cycle();
        zero_inputs();
        cycle();
        reset = 0;

        // Quiet from reset: idle after the 16th quiet edge.
        repeat (20) cycle();
        chk("idle2_quiet", {31'd0, idle2}, 32'd1);

        // Outstanding request on source 2 holds idle off until its response.
        reqFire[2] = 1; cycle(); reqFire[2] = 0;
        repeat (9) cycle();
        respFire[2] = 1; cycle(); respFire[2] = 0;
        repeat (18) cycle();

        // Same-cycle req+resp: no count change, no error, but not quiet.
        reqFire[1] = 1; respFire[1] = 1; cycle(); reqFire[1] = 0; respFire[1] = 0;
        repeat (18) cycle();

        // Narrow instance: saturation at 3, then drain and underflow.
        req2 = 1'b1;
        repeat (3) cycle();
        chk("of2_pre", {31'd0, of2}, 32'd0);
        cycle();
        chk("of2_set", {31'd0, of2}, 32'd1);
        chk("idle2_busy", {31'd0, idle2}, 32'd0);
        req2 = 1'b0; resp2 = 1'b1;
        repeat (3) cycle();
        chk("uf2_pre", {31'd0, uf2}, 32'd0);
        cycle();
        chk("uf2_set", {31'd0, uf2}, 32'd1);
        chk("src2", {31'd0, src2}, 32'd0);
        resp2 = 1'b0;
        cycle();
        chk("idle2_back", {31'd0, idle2}, 32'd1);

        // Underflow on 3 latches errSrc; later errors on 0 and overflow on 1 leave it.
        respFire[3] = 1; cycle(); respFire[3] = 0;
        repeat (2) cycle();
        respFire[0] = 1; cycle(); respFire[0] = 0;
        reqFire[1] = 1;
        repeat (256) cycle();
        reqFire[1] = 0; respFire[1] = 1;
        repeat (255) cycle();
        respFire[1] = 0;
        repeat (17) cycle();

        // Stall timeout at limit 100 with a busy source and no commits.
        do_reset();
        stallLimit = 32'd100; busy[0] = 1;
        repeat (105) cycle();

        // Commits every 50 cycles keep the stall counter below the limit.
        do_reset();
        stallLimit = 32'd100; busy[0] = 1;
        for (int k = 0; k < 200; k++) begin
            commitValid = ((k % 50) == 49);
            cycle();
        end
        commitValid = 0;

        // Limit below current count never fires; a larger one applies at once.
        do_reset();
        busy[0] = 1; stallLimit = '0;
        repeat (30) cycle();
        stallLimit = 32'd10;
        repeat (20) cycle();
        stallLimit = 32'd60;
        repeat (12) cycle();

        // Init window holds idle low even when quiet.
        do_reset();
        zero_inputs();
        initFlag = 1;
        repeat (20) cycle();
        initFlag = 0;
        repeat (20) cycle();

        // Simultaneous errors: lowest index wins.
        do_reset();
        respFire = 4'b1010; cycle(); respFire = '0;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
